uart_rfifo_param: RTL

- Parametrised next-generation UART receive FIFO; sits between the receiver shift logic and the Wishbone register file (RBR read / LSR status).
- Stores DATA_W-bit characters with STAT_W per-character status bits (parity, framing, break).
- Adds programmable trigger level, full/empty flags and a counter-based error summary.
- Defines push/pop on empty and full cases explicitly.

---
 rtl/uart_rfifo_param.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rfifo_param.sv
// UART receive FIFO: stores {char, status} entries, tracks occupancy, sticky overrun
// and a running count of stored entries carrying a nonzero status.
module uart_rfifo_param #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 3,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic                     clk,
    input  logic                     wb_rst_i,
    input  logic                     fifo_reset,
    input  logic                     reset_status,
    input  logic                     push,
    input  logic [DATA_W+STAT_W-1:0] data_in,
    input  logic                     pop,
    input  logic [CNT_W-1:0]         trig_level,
    output logic [DATA_W+STAT_W-1:0] data_out,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full,
    output logic                     overrun,
    output logic                     error_bit,
    output logic                     trig_hit
);
    localparam int ENT_W = DATA_W + STAT_W;

    // An entry is an error entry when any of its status bits is set.
    function automatic logic has_err(input logic [ENT_W-1:0] ent);
        return |ent[STAT_W-1:0];
    endfunction

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d, bottom_q, bottom_d;
    logic [CNT_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
    logic             overrun_q, overrun_d;
    logic             do_push_s, do_pop_s, ovr_set_s, err_inc_s, err_dec_s;

    assign empty     = (count_q == {CNT_W{1'b0}});
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign error_bit = (err_cnt_q != {CNT_W{1'b0}});

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;
    assign ovr_set_s = push && full && !pop;
    assign err_inc_s = do_push_s && has_err(data_in);
    assign err_dec_s = do_pop_s && has_err(mem_q[bottom_q]);

    // Head entry is presented combinationally; zeros while empty.
    always_comb begin
        data_out = {ENT_W{1'b0}};
        if (!empty) begin
            data_out = mem_q[bottom_q];
        end else begin
            data_out = {ENT_W{1'b0}};
        end
    end

    assign trig_hit = (trig_level != {CNT_W{1'b0}}) && (count_q >= trig_level);

    // Next-state: flush, pointer/count/error bookkeeping and overrun.
    always_comb begin
        mem_d     = mem_q;
        top_d     = top_q;
        bottom_d  = bottom_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q;
        if (fifo_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = {ENT_W{1'b0}};
            end
            top_d     = {PTR_W{1'b0}};
            bottom_d  = {PTR_W{1'b0}};
            count_d   = {CNT_W{1'b0}};
            err_cnt_d = {CNT_W{1'b0}};
            overrun_d = 1'b0;
        end else begin
            // Clear the popped slot before writing, so a push into the same slot wins.
            if (do_pop_s) begin
                mem_d[bottom_q] = {ENT_W{1'b0}};
                bottom_d        = bottom_q + PTR_W'(1);
            end else begin
                bottom_d = bottom_q;
            end
            if (do_push_s) begin
                mem_d[top_q] = data_in;
                top_d        = top_q + PTR_W'(1);
            end else begin
                top_d = top_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
            if (err_inc_s && !err_dec_s) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end else if (err_dec_s && !err_inc_s) begin
                err_cnt_d = err_cnt_q - CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (reset_status) begin
                overrun_d = 1'b0;
            end else if (ovr_set_s) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
            top_q     <= {PTR_W{1'b0}};
            bottom_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            top_q     <= top_d;
            bottom_q  <= bottom_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            overrun_q <= overrun_d;
        end
    end
endmodule
